// File: rtl/op_issuer.sv
// op_issuer: turns queued host commands plus a load-data stream into the cycle-exact operation/in_data
// sequence for the 8x8 MAC array controller. Optional macro CMD_CHECK_EN enables illegal-command filtering.
module op_issuer #(
    parameter int unsigned W_WORDS     = 32,
    parameter int unsigned X_WORDS     = 80,
    parameter int unsigned CALC_CYCLES = 64,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd,
    input  logic        dat_valid,
    output logic        dat_ready,
    input  logic [31:0] dat,
    output logic [31:0] operation,
    output logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned MAX_LW  = (W_WORDS > X_WORDS) ? W_WORDS : X_WORDS;
    localparam int unsigned MAX_ALL = (MAX_LW > CALC_CYCLES) ? MAX_LW : CALC_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] W_LEN  = CW'(W_WORDS);
    localparam logic [CW-1:0] X_LEN  = CW'(X_WORDS);
    localparam logic [CW-1:0] CALC_T = CW'(CALC_CYCLES);
    localparam logic [CW-1:0] GAP_T  = CW'(GAP_CYCLES);

    localparam logic [3:0] MODE_CALC = 4'd1;
    localparam logic [3:0] MODE_LOAD = 4'd2;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, GAP} state_t;

    state_t        state;
    logic [17:0]   cmd_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len;
    logic [CW-1:0] cnt_inc;
    logic          cmd_bad;

    assign cnt_inc = cnt + CW'(1);

`ifdef CMD_CHECK_EN
    // W/X address beyond buffer 3, or a calc that selects a nonexistent W buffer / b-field.
    always_comb begin
        cmd_bad = 1'b0;
        if (cmd[3:0] == MODE_LOAD)
            cmd_bad = (cmd[6:4] > 3'd3);
        else if (cmd[3:0] == MODE_CALC)
            cmd_bad = cmd[7] | cmd[11];
    end
`else
    always_comb begin
        cmd_bad = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            cnt       <= '0;
            len       <= '0;
            operation <= '0;
            in_data   <= '0;
            cmd_ready <= 1'b1;
            dat_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    operation <= '0;
                    if (cmd_valid) begin
                        cmd_q <= cmd;
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else if (cmd[3:0] == MODE_LOAD) begin
                            state     <= LOAD;
                            cmd_ready <= 1'b0;
                            dat_ready <= 1'b1;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            len       <= cmd[7] ? W_LEN : X_LEN;
                        end else if (cmd[3:0] == MODE_CALC) begin
                            state     <= CALC;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            operation <= {14'b0, cmd};
                            cnt       <= CW'(1);
                            done      <= (CALC_T == CW'(1));
                        end
                    end
                end
                // cnt == len means the last beat is on the bus this cycle; leave one cycle later
                // so GAP starts with operation already back at zero.
                LOAD: begin
                    if (cnt == len) begin
                        state     <= GAP;
                        operation <= '0;
                        cnt       <= '0;
                    end else if (dat_valid) begin
                        operation <= {14'b0, cmd_q};
                        in_data   <= dat;
                        cnt       <= cnt_inc;
                        if (cnt_inc == len) begin
                            done      <= 1'b1;
                            dat_ready <= 1'b0;
                        end
                    end else begin
                        operation <= '0;
                    end
                end
                CALC: begin
                    if (cnt == CALC_T) begin
                        state     <= GAP;
                        operation <= '0;
                        cnt       <= '0;
                    end else begin
                        cnt  <= cnt_inc;
                        done <= (cnt_inc == CALC_T);
                    end
                end
                GAP: begin
                    operation <= '0;
                    if (cnt_inc == GAP_T) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_issuer.sv
// Self-checking bench for op_issuer: scoreboard of expected operation/in_data/done per issued cycle.
// Build with +define+CMD_CHECK_EN to exercise the command filter.
module tb_op_issuer;

    localparam int W_WORDS     = 32;
    localparam int X_WORDS     = 80;
    localparam int CALC_CYCLES = 64;
    localparam int GAP_CYCLES  = 1;

`ifdef CMD_CHECK_EN
    localparam logic [17:0] CALC_CMD = 18'h10001;
`else
    localparam logic [17:0] CALC_CMD = 18'h10801;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, cmd_valid, dat_valid;
    logic [17:0] cmd;
    logic [31:0] dat;
    logic        cmd_ready, dat_ready, busy, done, err;
    logic [31:0] operation, in_data;

    typedef struct {
        logic [31:0] op;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    op_issuer #(
        .W_WORDS    (W_WORDS),
        .X_WORDS    (X_WORDS),
        .CALC_CYCLES(CALC_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd      (cmd),
        .dat_valid(dat_valid),
        .dat_ready(dat_ready),
        .dat      (dat),
        .operation(operation),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; dat_valid = 1'b0; cmd = '0; dat = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (operation !== 32'h0 || in_data !== 32'h0 || cmd_ready !== 1'b1 || dat_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state op=%h in_data=%h cmd_ready=%b dat_ready=%b busy=%b done=%b err=%b expected 0,0,1,0,0,0,0",
                     operation, in_data, cmd_ready, dat_ready, busy, done, err);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Tail shared by every stream: one GAP cycle of zero, then back to IDLE.
    task automatic check_tail(input string name);
        checks++;
        if (operation !== 32'h0 || done !== 1'b0 || busy !== 1'b1 || dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap op=%h done=%b busy=%b dat_ready=%b expected 0,0,1,0", name, operation, done, busy, dat_ready);
        end
        @(negedge clk);
        checks++;
        if (operation !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1 || dat_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle op=%h busy=%b cmd_ready=%b dat_ready=%b expected 0,0,1,0", name, operation, busy, cmd_ready, dat_ready);
        end
    endtask

    task automatic test_load_stream(input logic [17:0] c, input int n, input logic [31:0] base, input bit stall);
        exp_t e;
        int   sent  = 0;
        int   got   = 0;
        int   dones = 0;
        int   cyc   = 0;
        bit   acc   = 1'b0;
        @(negedge clk); cmd = c; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || dat_ready !== 1'b1 || busy !== 1'b1 || operation !== 32'h0) begin
            errors++;
            $display("FAIL load_accept cmd_ready=%b dat_ready=%b busy=%b op=%h expected 0,1,1,0", cmd_ready, dat_ready, busy, operation);
        end
        while ((sent < n || acc) && cyc < 1000) begin
            checks++;
            if (acc) begin
                e = sb.pop_front();
                got++;
                if (e.last) dones++;
                if (operation !== e.op || in_data !== e.data || done !== e.last) begin
                    errors++;
                    $display("FAIL load_beat op=%h in_data=%h done=%b expected op=%h in_data=%h done=%b",
                             operation, in_data, done, e.op, e.data, e.last);
                end
            end else if (operation !== 32'h0 || done !== 1'b0) begin
                errors++;
                $display("FAIL load_stall op=%h done=%b expected 0,0", operation, done);
            end
            acc = 1'b0;
            dat_valid = 1'b0;
            if (sent < n && !(stall && (cyc % 3 == 2))) begin
                dat_valid = 1'b1;
                dat = base + 32'(sent + 1);
                if (dat_ready === 1'b1) begin
                    acc    = 1'b1;
                    e.op   = {14'b0, c};
                    e.data = dat;
                    e.last = (sent + 1 == n);
                    sb.push_back(e);
                    sent++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        dat_valid = 1'b0;
        check_tail("load");
        checks++;
        if (got !== n || dones !== 1 || cyc >= 1000) begin
            errors++;
            $display("FAIL load_count writes=%0d dones=%0d cycles=%0d expected writes=%0d dones=1 cycles<1000", got, dones, cyc, n);
        end
    endtask

    task automatic test_calc_stream(input logic [17:0] c, input int n, input bit freeze);
        exp_t        e;
        int          left    = n;
        int          dones   = 0;
        int          zeros   = 0;
        int          cyc     = 0;
        bit          en_prev = 1'b1;
        bit          started = 1'b0;
        logic [31:0] last_op = '0;
        logic        last_dn = 1'b0;
        while ((left > 0 || sb.size() > 0) && cyc < 1000) begin
            checks++;
            if (!en_prev) begin
                if (operation !== last_op || done !== last_dn) begin
                    errors++;
                    $display("FAIL calc_freeze op=%h done=%b expected op=%h done=%b", operation, done, last_op, last_dn);
                end
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                last_op = e.op; last_dn = e.last; zeros = 0;
                if (e.last) dones++;
                if (operation !== e.op || done !== e.last) begin
                    errors++;
                    $display("FAIL calc_op op=%h done=%b expected op=%h done=%b", operation, done, e.op, e.last);
                end
            end else begin
                last_op = '0; last_dn = 1'b0; zeros++;
                if (operation !== 32'h0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL calc_idle op=%h done=%b expected 0,0", operation, done);
                end
            end
            en_prev = !(freeze && cyc >= 20 && cyc < 25);
            enable = en_prev;
            cmd_valid = 1'b0;
            if (left > 0) begin
                cmd_valid = 1'b1;
                cmd = c;
                if (cmd_ready === 1'b1 && en_prev) begin
                    if (started) begin
                        checks++;
                        if (zeros !== GAP_CYCLES + 1) begin
                            errors++;
                            $display("FAIL calc_spacing zero_cycles=%0d expected %0d", zeros, GAP_CYCLES + 1);
                        end
                    end
                    started = 1'b1;
                    left--;
                    for (int k = 1; k <= CALC_CYCLES; k++) begin
                        e.op = {14'b0, c}; e.data = '0; e.last = (k == CALC_CYCLES);
                        sb.push_back(e);
                    end
                end
            end
            cyc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        enable = 1'b1;
        check_tail("calc");
        checks++;
        if (dones !== n || cyc >= 1000) begin
            errors++;
            $display("FAIL calc_count dones=%0d cycles=%0d expected dones=%0d cycles<1000", dones, cyc, n);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk); cmd = 18'h00082; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; dat_valid = 1'b1; dat = 32'h55;
        repeat (3) @(negedge clk);
        checks++;
        if (operation !== 32'h82 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midstream_active op=%h busy=%b expected 00000082,1", operation, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (operation !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1 || dat_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset op=%h busy=%b cmd_ready=%b dat_ready=%b done=%b expected 0,0,1,0,0",
                     operation, busy, cmd_ready, dat_ready, done);
        end
        dat_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_cmd_check();
`ifdef CMD_CHECK_EN
        @(negedge clk); cmd = 18'h00081; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || operation !== 32'h0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_cmd err=%b op=%h cmd_ready=%b busy=%b expected 1,0,1,0", err, operation, cmd_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || operation !== 32'h0) begin
            errors++;
            $display("FAIL err_sticky err=%b op=%h expected 1,0", err, operation);
        end
`else
        @(negedge clk); cmd = 18'h00003; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        checks++;
        if (err !== 1'b0 || operation !== 32'h0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL dropped_mode err=%b op=%h cmd_ready=%b busy=%b done=%b expected 0,0,1,0,0",
                     err, operation, cmd_ready, busy, done);
        end
        @(negedge clk);
        checks++;
        if (operation !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dropped_mode_after op=%h busy=%b expected 0,0", operation, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_stream(18'h00082, W_WORDS, 32'h0, 1'b0);
        test_load_stream(18'h00002, X_WORDS, 32'hA000_0000, 1'b1);
        test_calc_stream(CALC_CMD, 2, 1'b0);
        test_calc_stream(CALC_CMD, 1, 1'b1);
        test_reset_midstream();
        test_load_stream(18'h000B2, W_WORDS, 32'h0BAD_0000, 1'b1);
        test_cmd_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
